// File: rtl/tensor_issue_if.sv
// Handshake bundle between the tensor issue scheduler (master) and its
// requesters / PE group / writeback path (slave).
interface tensor_issue_if #(
  parameter int unsigned NUM_WARPS = 4,
  parameter int unsigned NUM_TILES = 2,
  parameter int unsigned NUM_STEPS = 4,
  parameter int unsigned XLEN      = 32
);
  localparam int unsigned WW = (NUM_WARPS > 1) ? $clog2(NUM_WARPS) : 1;
  localparam int unsigned TW = (NUM_TILES > 1) ? $clog2(NUM_TILES) : 1;
  localparam int unsigned SW = (NUM_STEPS > 1) ? $clog2(NUM_STEPS) : 1;
  localparam int unsigned RW = $clog2(XLEN);

  logic [NUM_WARPS-1:0]    req_valid;
  logic [NUM_WARPS*RW-1:0] req_rd;
  logic [NUM_WARPS-1:0]    req_ready;
  logic                    pe_valid;
  logic                    pe_ready;
  logic [WW-1:0]           pe_wid;
  logic [TW-1:0]           pe_tile;
  logic [SW-1:0]           pe_step;
  logic                    pe_first;
  logic                    pe_last;
  logic                    done_valid;
  logic                    done_ready;
  logic [WW-1:0]           done_wid;
  logic [RW-1:0]           done_rd;
  logic                    busy;

  modport master (
    input  req_valid, req_rd, pe_ready, done_ready,
    output req_ready, pe_valid, pe_wid, pe_tile, pe_step, pe_first, pe_last,
           done_valid, done_wid, done_rd, busy
  );

  modport slave (
    output req_valid, req_rd, pe_ready, done_ready,
    input  req_ready, pe_valid, pe_wid, pe_tile, pe_step, pe_first, pe_last,
           done_valid, done_wid, done_rd, busy
  );
endinterface

// File: rtl/tensor_issue_ctrl.sv
// Round-robin warp scheduler that sequences one MMA op at a time through
// NUM_TILES x NUM_STEPS PE beats, drains the pipe, then reports completion.
module tensor_issue_ctrl #(
  parameter int unsigned NUM_WARPS    = 4,
  parameter int unsigned NUM_TILES    = 2,
  parameter int unsigned NUM_STEPS    = 4,
  parameter int unsigned PIPE_LATENCY = 3,
  parameter int unsigned XLEN         = 32
) (
  input  logic          clk,
  input  logic          reset,
  tensor_issue_if.master bus
);
  localparam int unsigned WW         = (NUM_WARPS > 1) ? $clog2(NUM_WARPS) : 1;
  localparam int unsigned TW         = (NUM_TILES > 1) ? $clog2(NUM_TILES) : 1;
  localparam int unsigned SW         = (NUM_STEPS > 1) ? $clog2(NUM_STEPS) : 1;
  localparam int unsigned RW         = $clog2(XLEN);
  localparam int unsigned DW         = (PIPE_LATENCY > 1) ? $clog2(PIPE_LATENCY) : 1;
  localparam int unsigned DRAIN_INIT = (PIPE_LATENCY > 0) ? PIPE_LATENCY - 1 : 0;

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, RESP} state_t;

  state_t        state, state_n;
  logic [WW-1:0] rr_ptr, rr_ptr_n;
  logic [TW-1:0] tile, tile_n;
  logic [SW-1:0] step, step_n;
  logic [DW-1:0] drain_cnt, drain_cnt_n;
  logic [WW-1:0] wid, wid_n;
  logic [RW-1:0] rd, rd_n;

  logic [WW-1:0] grant;
  logic [WW-1:0] cand;
  logic          found;
  logic [RW-1:0] rd_arr [NUM_WARPS];

  // Unpack the flat per-warp destination register bus
  always_comb begin
    for (int w = 0; w < NUM_WARPS; w++) begin
      rd_arr[w] = bus.req_rd[w*RW +: RW];
    end
  end

  // First requesting warp at or after rr_ptr, wrapping
  always_comb begin
    found = 1'b0;
    grant = '0;
    cand  = '0;
    for (int i = 0; i < NUM_WARPS; i++) begin
      cand = WW'((int'(rr_ptr) + i) % NUM_WARPS);
      if (!found && bus.req_valid[cand]) begin
        found = 1'b1;
        grant = cand;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      rr_ptr    <= '0;
      tile      <= '0;
      step      <= '0;
      drain_cnt <= '0;
      wid       <= '0;
      rd        <= '0;
    end else begin
      state     <= state_n;
      rr_ptr    <= rr_ptr_n;
      tile      <= tile_n;
      step      <= step_n;
      drain_cnt <= drain_cnt_n;
      wid       <= wid_n;
      rd        <= rd_n;
    end
  end

  always_comb begin
    state_n        = state;
    rr_ptr_n       = rr_ptr;
    tile_n         = tile;
    step_n         = step;
    drain_cnt_n    = drain_cnt;
    wid_n          = wid;
    rd_n           = rd;
    bus.req_ready  = '0;
    bus.pe_valid   = 1'b0;
    bus.pe_first   = 1'b0;
    bus.pe_last    = 1'b0;
    bus.done_valid = 1'b0;
    bus.pe_wid     = wid;
    bus.pe_tile    = tile;
    bus.pe_step    = step;
    bus.done_wid   = wid;
    bus.done_rd    = rd;
    bus.busy       = (state != IDLE);

    unique case (state)
      IDLE: begin
        // Grant is suppressed while reset is asserted so no handshake is lost
        if (found && !reset) begin
          bus.req_ready[grant] = 1'b1;
          wid_n    = grant;
          rd_n     = rd_arr[grant];
          rr_ptr_n = (grant == WW'(NUM_WARPS - 1)) ? '0 : grant + WW'(1);
          tile_n   = '0;
          step_n   = '0;
          state_n  = ISSUE;
        end
      end
      ISSUE: begin
        bus.pe_valid = 1'b1;
        bus.pe_first = (step == '0);
        bus.pe_last  = (step == SW'(NUM_STEPS - 1));
        if (bus.pe_ready) begin
          if (step == SW'(NUM_STEPS - 1)) begin
            step_n = '0;
            if (tile == TW'(NUM_TILES - 1)) begin
              tile_n = '0;
              if (PIPE_LATENCY > 0) begin
                drain_cnt_n = DW'(DRAIN_INIT);
                state_n     = DRAIN;
              end else begin
                state_n = RESP;
              end
            end else begin
              tile_n = tile + TW'(1);
            end
          end else begin
            step_n = step + SW'(1);
          end
        end
      end
      DRAIN: begin
        if (drain_cnt == '0) begin
          state_n = RESP;
        end else begin
          drain_cnt_n = drain_cnt - DW'(1);
        end
      end
      RESP: begin
        bus.done_valid = 1'b1;
        if (bus.done_ready) begin
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end
endmodule
